uart_tx_fifo: RTL and testbench

- Parametrised successor to the fixed 12 Mbaud transmit path used for trace output.
- Byte FIFO of configurable depth, then a UART serialiser with configurable data and stop bits.
- Optional CTS flow control and a sticky overflow flag.
- Sits between the packet marshaller (`DataVal`/`DataReady`) and the `uarttx` pin, in the system clock domain.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Returns the clock divider, or 0 when the ratio is unusable.
    function automatic int calc_div(input int clock_hz, input int baud);
        if (baud <= 0) return 0;
        if ((clock_hz % baud) != 0) return 0;
        if ((clock_hz / baud) < 2) return 0;
        return clock_hz / baud;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level/full/empty and a fall-through read port.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    // NOTE: combinational logic uses blocking '='; flops use '<=' so every flop samples pre-edge values.
    always_comb begin
        do_wr    = wr && !full_q;
        do_rd    = rd && !empty_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        level_d  = level_q + LVL_W'(do_wr) - LVL_W'(do_rd);
        full_d   = (level_d == LVL_W'(DEPTH));
        empty_d  = (level_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a serialiser with optional CTS flow control.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCKFRQ  = 48_000_000,
    parameter int BAUDRATE  = 12_000_000,
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [7:0]                    wdata,
    output logic                          full,
    output logic [level_width(DEPTH)-1:0] level,
    input  logic                          flow_en,
    input  logic                          cts_n,
    output logic                          ovf,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy
);

    localparam int DIV   = calc_div(CLOCKFRQ, BAUDRATE);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    if (DIV == 0) begin : g_bad_div
        $error("uart_tx_fifo: CLOCKFRQ/BAUDRATE must be an integer >= 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic                   cts_meta_q, cts_meta_d;
    logic                   cts_sync_q, cts_sync_d;

    logic                   pop, start_ok, last_cnt;
    logic                   fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   unused_wdata;

    assign unused_wdata = ^wdata;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (pop),
        .din   (wdata[DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cts_meta_d = cts_n;
        cts_sync_d = cts_meta_q;
        // Set wins over clear so an overflow coinciding with clr_ovf is never lost.
        ovf_d      = (wr && fifo_full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        start_ok   = !fifo_empty && (!flow_en || !cts_sync_q);
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        pop      = 1'b0;
        last_cnt = (cnt_q == CNT_W'(DIV - 1));

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
            end
            ST_START: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame launch from IDLE, or back-to-back at the final stop cycle.
        if (start_ok && (state_q == ST_IDLE || (state_q == ST_STOP && state_d == ST_IDLE))) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            cts_meta_q <= cts_meta_d;
            cts_sync_q <= cts_sync_d;
        end
    end

    assign full = fifo_full;
    assign ovf  = ovf_q;
    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench: a line decoder checks every frame against a byte queue model.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr, flow_en, cts_n, clr_ovf;
    logic [7:0] wdata;
    logic       full, ovf, tx, busy;
    logic [4:0] level;

    logic       wr7;
    logic [7:0] wdata7;
    logic       full7, ovf7, tx7, busy7;
    logic [4:0] level7;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    int         rx_count = 0;
    bit         mon_en   = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_b;

    always #5 clk = ~clk;

    uart_tx_fifo u_dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .wdata   (wdata),
        .full    (full),
        .level   (level),
        .flow_en (flow_en),
        .cts_n   (cts_n),
        .ovf     (ovf),
        .clr_ovf (clr_ovf),
        .tx      (tx),
        .busy    (busy)
    );

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr7),
        .wdata   (wdata7),
        .full    (full7),
        .level   (level7),
        .flow_en (1'b0),
        .cts_n   (1'b1),
        .ovf     (ovf7),
        .clr_ovf (1'b0),
        .tx      (tx7),
        .busy    (busy7)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ideal line level during bit period k of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int db, input int k);
        if (k == 0) return 1'b0;
        if (k <= db) return b[k-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        wr    = 1'b1;
        wdata = b;
        if (accept) begin
            exp_q.push_back(b);
            n_acc++;
        end
        tick();
        wr = 1'b0;
    endtask

    task automatic busy_run(output int run);
        bit seen = 1'b0;
        run = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                run++;
            end else if (seen) begin
                break;
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1'b1);
    endtask

    // Line decoder: samples mid-bit and checks each frame against the head of the byte queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                check("rx_start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rx_b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                check("rx_stop_bit", tx, 1'b1);
                check("rx_frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("rx_byte", rx_b, exp_q.pop_front());
                rx_count++;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, errs, lows, lat;
        bit found;

        rst = 1'b0; wr = 1'b0; wdata = '0; flow_en = 1'b0; cts_n = 1'b0; clr_ovf = 1'b0;
        wr7 = 1'b0; wdata7 = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_level", level, 0);
        check("rst_full", full, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) tick();

        // Single 8N1 frame, exact waveform and latency.
        write_byte(8'hA5, 1'b1);
        @(negedge clk);
        check("t1_level_n1", level, 1);
        check("t1_tx_n1", tx, 1'b1);
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (tx !== exp_line(8'hA5, 8, k / DIV)) errs++;
            if (busy !== 1'b1) errs++;
        end
        check("t1_wave_errors", errs, 0);
        @(negedge clk);
        check("t1_busy_end", busy, 1'b0);
        check("t1_tx_end", tx, 1'b1);
        wait_drain("t1_drain", 100);

        // Back-to-back frames leave no idle gap.
        fork
            begin
                write_byte(8'h00, 1'b1);
                write_byte(8'hFF, 1'b1);
                write_byte(8'h55, 1'b1);
            end
            busy_run(run);
        join
        check("t2_busy_run", run, 3 * FRAME);
        wait_drain("t2_drain", 200);

        // 7 data bits, 2 stop bits; bit 7 of the written byte must be ignored.
        wr7 = 1'b1; wdata7 = 8'hDA;
        tick();
        wr7 = 1'b0;
        @(negedge clk);
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (tx7 !== exp_line(8'hDA & 8'h7F, 7, k / DIV)) errs++;
            if (busy7 !== 1'b1) errs++;
        end
        check("t7_wave_errors", errs, 0);
        @(negedge clk);
        check("t7_busy_end", busy7, 1'b0);

        // CTS held off: FIFO fills, the 17th byte overflows.
        flow_en = 1'b1; cts_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < DEPTH + 1; i++) write_byte(8'($urandom), i < DEPTH);
        @(negedge clk);
        check("t3_level", level, DEPTH);
        check("t3_full", full, 1'b1);
        check("t3_ovf", ovf, 1'b1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t3_tx_held", lows, 0);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("t3_ovf_cleared", ovf, 1'b0);
        @(posedge clk);
        #1 cts_n = 1'b0;
        wait_drain("t3_drain", DEPTH * FRAME + 100);
        repeat (60) @(negedge clk);

        // CTS raised mid-frame: frame completes, next one waits for the synchronised release.
        write_byte(8'h3A, 1'b1);
        write_byte(8'hC4, 1'b1);
        repeat (10) tick();
        cts_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_first_frame_end", found, 1'b1);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("t4_withheld", lows, 0);
        check("t4_level_pending", level, 1);
        // Two synchroniser flops, then one edge to launch the start bit.
        @(posedge clk);
        #1 cts_n = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                lat = k;
                break;
            end
        end
        check("t4_cts_latency", lat, 4);
        wait_drain("t4_drain", 200);

        // Write while full in the very cycle a pop happens: still dropped.
        cts_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom), 1'b1);
        cts_n = 1'b0;
        @(negedge clk);
        check("t5_full_before", full, 1'b1);
        check("t5_ovf_before", ovf, 1'b0);
        tick();
        tick();
        write_byte(8'h77, 1'b0);
        @(negedge clk);
        check("t5_level", level, DEPTH - 1);
        check("t5_ovf", ovf, 1'b1);
        check("t5_full_after", full, 1'b0);
        check("t5_busy", busy, 1'b1);
        wait_drain("t5_drain", DEPTH * FRAME + 100);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Reset in the middle of DATA aborts the frame and flushes the FIFO.
        flow_en = 1'b0;
        mon_en  = 1'b0;
        write_byte(8'h12, 1'b0);
        write_byte(8'h34, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_tx", tx, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_level", level, 0);
        check("t6_rst_full", full, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (50) tick();
        mon_en = 1'b1;
        write_byte(8'h3C, 1'b1);
        wait_drain("t6_drain", 100);

        // Random traffic with CTS toggling; the queue never exceeds DEPTH so all writes land.
        flow_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) cts_n = ~cts_n;
            if ($urandom_range(2) == 0 && exp_q.size() < DEPTH) write_byte(8'($urandom), 1'b1);
            else tick();
        end
        cts_n = 1'b0;
        wait_drain("rand_drain", DEPTH * FRAME + 200);
        repeat (60) @(negedge clk);
        check("rand_ovf", ovf, 1'b0);
        check("total_frames", rx_count, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
